hicore_alu_q: RTL and testbench
===============================

# hicore_alu_q

Parametrised integer ALU execution unit with a buffered, back-pressurable writeback port. It sits between the issue stage and the ROB writeback arbiter. One RV32I/RV64I-style ALU operation is accepted per cycle and computed combinationally. The result is enqueued with its ROB pointer and info payload into a DEPTH-entry FIFO, which drains to writeback under a valid/ready handshake. Cancelled entries are dropped silently, and a commit flush empties the unit.

## Interface
- XLEN, 32: datapath width; 32 or 64.
- PTR_W, 5: ROB pointer width.
- INFO_W, 8: opaque writeback info width, passed through unchanged.
- DEPTH, 4: result FIFO entries; power of two, ≥2.
---
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  issue offers an op.
- in_ready  out  1  unit can accept; equals ~full.
- in_cancel  in  1  op is squashed; it is enqueued but never written back.
- src1, src2  in  XLEN  operands.
- alu_msg  in  3  funct3 encoding.
- alu_dir  in  1  funct7[5]: sub / sra select.
- alu_op, lui_op, auipc_op  in  1  op class (at most one set).
- in_ptr  in  PTR_W  ROB pointer.
- in_info  in  INFO_W  writeback info.
- wb_valid  out  1  head entry valid and not cancelled.
- wb_ready  in  1  writeback arbiter accepts.
- wb_ptr  out  PTR_W  head entry ROB pointer.
- wb_data  out  XLEN  head entry result.
- wb_info  out  INFO_W  head entry info.
- flush  in  1  commit-stage flush.
- occupancy  out  log2(DEPTH)+1  current entry count.

## Operation
- Result select:
  - lui_op / auipc_op: add, src1+src2.
  - alu_op with alu_msg:
    - 000: add, or sub when alu_dir=1.
    - 001: sll.
    - 010: slt.
    - 011: sltu.
    - 100: xor.
    - 101: srl, or sra when alu_dir=1.
    - 110: or.
    - 111: and.
  - No class bit set: result 0.
- Shift amount: src2[log2(XLEN)-1:0]. Arithmetic right shift fills with src1[XLEN-1].
- slt/sltu: XLEN+1-bit subtract. The extension bit is the sign for slt and 0 for sltu. Result is {XLEN-1 zeros, borrow}.
- Add/sub wraps modulo 2^XLEN. No exceptions.
- Enqueue: on in_valid & in_ready & ~flush, write {result, in_ptr, in_info, in_cancel} at wr_ptr.
- Head pop: happens when the head is cancelled, or when wb_valid & wb_ready.
  - A cancelled head is popped unconditionally, one per cycle, without asserting wb_valid.
- Simultaneous enqueue and pop: both occur; occupancy is unchanged.
  - When full, in_ready=0 even if a pop occurs the same cycle. There is no combinational ready path.
- Pointers wrap modulo DEPTH. occupancy ranges 0..DEPTH. full = (occupancy==DEPTH), empty = (occupancy==0).
- Flush:
  - Same edge: wr_ptr=rd_ptr=0 and occupancy=0.
  - The input offered in the flush cycle is discarded.
  - wb_valid is forced 0 combinationally during the flush cycle, so no handshake completes.
- Reset behaves as flush. All FIFO storage is don't-care after reset.

## Timing
- Reset values:
  - in_ready=1, wb_valid=0, occupancy=0.
  - wb_ptr, wb_data and wb_info are 0 while empty (outputs are gated by ~empty).
- Latency: accept at edge N; the entry is wb_valid from cycle N+1 if the FIFO was empty.
- Sustained throughput: 1 op/cycle when wb_ready is held 1.
- With wb_ready=0, DEPTH consecutive accepts fill the FIFO. in_ready falls in the cycle after the DEPTH-th accept.
- wb_valid and the wb_* outputs depend only on registers, plus flush gating.
- in_ready is registered-derived, from occupancy only.
- Reset asserted mid-stream: all entries are lost and no writeback occurs in the reset cycle. Operation resumes the cycle after rst deasserts.

## Test plan
- Arithmetic, XLEN=32:
  - sub 5-7 → 0xFFFFFFFE.
  - sra 0x80000000 by 4 → 0xF8000000.
  - srl 0x80000000 by 4 → 0x08000000.
  - slt(-1,1)=1, sltu(-1,1)=0.
  - Each appears on wb_data one cycle after accept, with matching ptr and info.
- Backpressure, DEPTH=4:
  - Hold wb_ready=0 and issue 5 ops.
  - in_ready drops after the 4th accept and occupancy=4.
  - Release wb_ready: results drain in order (ptr 0,1,2,3), then the 5th op is accepted.
- Cancel: issue ptrs 1,2,3 with 2 cancelled and wb_ready=1 → wb handshakes for ptrs 1 and 3 only; ptr 2 is never wb_valid.
- Flush with 3 entries queued plus an op offered the same cycle:
  - Next cycle occupancy=0 and wb_valid=0.
  - No handshake occurs in the flush cycle.
  - The offered op never appears.
- Simultaneous push and pop at occupancy 2 for 10 cycles → occupancy stays 2; pointers wrap correctly and order is preserved.
- XLEN=64 build: sll 1 by 63 → 0x8000000000000000; add wraps 0xFFFF_FFFF_FFFF_FFFF+1=0.

Source files
------------

// File: rtl/hicore_alu_q_if.sv
// Issue-side and writeback-side bus of the ALU execution unit.
// master = issue stage / writeback arbiter side, slave = the execution unit.
interface hicore_alu_q_if #(
  parameter int XLEN   = 32,
  parameter int PTR_W  = 5,
  parameter int INFO_W = 8,
  parameter int DEPTH  = 4
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic              in_cancel;
  logic [XLEN-1:0]   src1;
  logic [XLEN-1:0]   src2;
  logic [2:0]        alu_msg;
  logic              alu_dir;
  logic              alu_op;
  logic              lui_op;
  logic              auipc_op;
  logic [PTR_W-1:0]  in_ptr;
  logic [INFO_W-1:0] in_info;
  logic              wb_valid;
  logic              wb_ready;
  logic [PTR_W-1:0]  wb_ptr;
  logic [XLEN-1:0]   wb_data;
  logic [INFO_W-1:0] wb_info;
  logic              flush;
  logic [OCC_W-1:0]  occupancy;

  modport master (
    output in_valid, in_cancel, src1, src2, alu_msg, alu_dir, alu_op, lui_op,
           auipc_op, in_ptr, in_info, wb_ready, flush,
    input  in_ready, wb_valid, wb_ptr, wb_data, wb_info, occupancy
  );

  modport slave (
    input  in_valid, in_cancel, src1, src2, alu_msg, alu_dir, alu_op, lui_op,
           auipc_op, in_ptr, in_info, wb_ready, flush,
    output in_ready, wb_valid, wb_ptr, wb_data, wb_info, occupancy
  );
endinterface

// File: rtl/hicore_alu_q.sv
// Integer ALU execution unit: combinational RV32I/RV64I-style ALU feeding a
// DEPTH-entry result FIFO that drains to ROB writeback over valid/ready.
// Cancelled entries are popped silently; flush/reset empty the unit.
module hicore_alu_q #(
  parameter int XLEN   = 32,
  parameter int PTR_W  = 5,
  parameter int INFO_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic clk,
  input  logic rst,
  hicore_alu_q_if.slave bus
);
  localparam int AW   = $clog2(DEPTH);
  localparam int SH_W = $clog2(XLEN);

  // ALU result for one issued op; operands are treated as raw bit vectors and
  // interpreted signed only where the operation calls for it.
  function automatic logic [XLEN-1:0] alu_result(
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b,
    input logic [2:0]      msg,
    input logic            dir,
    input logic            is_alu,
    input logic            is_upper
  );
    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN:0]   ext_a;
    logic signed [XLEN:0]   ext_b;
    logic signed [XLEN:0]   diff;
    logic [SH_W-1:0]        shamt;
    logic                   signed_cmp;
    logic [XLEN-1:0]        res;
    a_s        = a;
    shamt      = b[SH_W-1:0];
    // slt extends with the sign bit, sltu with zero; the borrow of the
    // XLEN+1-bit difference is then the less-than answer in both cases.
    signed_cmp = (msg == 3'b010);
    ext_a      = {signed_cmp & a[XLEN-1], a};
    ext_b      = {signed_cmp & b[XLEN-1], b};
    diff       = ext_a - ext_b;
    res        = '0;
    if (is_upper) begin
      res = a + b;
    end else if (is_alu) begin
      case (msg)
        3'b000:  res = dir ? (a - b) : (a + b);
        3'b001:  res = a << shamt;
        3'b010,
        3'b011:  res = {{(XLEN-1){1'b0}}, diff[XLEN]};
        3'b100:  res = a ^ b;
        3'b101:  res = dir ? XLEN'(a_s >>> shamt) : (a >> shamt);
        3'b110:  res = a | b;
        default: res = a & b;
      endcase
    end
    return res;
  endfunction

  // FIFO storage (data path, never reset) and control state
  logic [XLEN-1:0]   data_q   [DEPTH];
  logic [PTR_W-1:0]  ptr_q    [DEPTH];
  logic [INFO_W-1:0] info_q   [DEPTH];
  logic              cancel_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       occ_q;

  logic [XLEN-1:0]   result;
  logic              empty;
  logic              full;
  logic              head_cancel;
  logic              wb_valid_int;
  logic              push;
  logic              pop;

  assign empty        = (occ_q == '0);
  assign full         = (occ_q == (AW+1)'(DEPTH));
  assign head_cancel  = ~empty & cancel_q[rd_ptr_q];
  // flush (and reset, which acts as a flush) kill the handshake in their cycle
  assign wb_valid_int = ~empty & ~cancel_q[rd_ptr_q] & ~bus.flush & ~rst;
  assign push         = bus.in_valid & ~full & ~bus.flush;
  assign pop          = head_cancel | (wb_valid_int & bus.wb_ready);

  assign result = alu_result(bus.src1, bus.src2, bus.alu_msg, bus.alu_dir,
                             bus.alu_op, bus.lui_op | bus.auipc_op);

  assign bus.in_ready  = ~full;
  assign bus.wb_valid  = wb_valid_int;
  assign bus.wb_ptr    = empty ? '0 : ptr_q[rd_ptr_q];
  assign bus.wb_data   = empty ? '0 : data_q[rd_ptr_q];
  assign bus.wb_info   = empty ? '0 : info_q[rd_ptr_q];
  assign bus.occupancy = occ_q;

  // Entry write: payload captured at the write pointer on every accept
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q]   <= result;
      ptr_q[wr_ptr_q]    <= bus.in_ptr;
      info_q[wr_ptr_q]   <= bus.in_info;
      cancel_q[wr_ptr_q] <= bus.in_cancel;
    end
  end

  // Pointer and occupancy control; reset and flush both empty the FIFO
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + (AW+1)'(1);
        2'b01:   occ_q <= occ_q - (AW+1)'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end
endmodule

// File: tb/tb_hicore_alu_q.sv
// Directed bench for hicore_alu_q: table of ALU vectors on a 32-bit build,
// hand sequences for backpressure, cancel, flush, reset and steady-state
// push/pop, plus a few checks on a 64-bit build.
module tb_hicore_alu_q;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hicore_alu_q_if #(.XLEN(32), .PTR_W(5), .INFO_W(8), .DEPTH(4)) b32 ();
  hicore_alu_q_if #(.XLEN(64), .PTR_W(5), .INFO_W(8), .DEPTH(4)) b64 ();

  hicore_alu_q #(.XLEN(32), .PTR_W(5), .INFO_W(8), .DEPTH(4)) dut32 (
    .clk(clk), .rst(rst), .bus(b32));
  hicore_alu_q #(.XLEN(64), .PTR_W(5), .INFO_W(8), .DEPTH(4)) dut64 (
    .clk(clk), .rst(rst), .bus(b64));

  int nvec  = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // cls = {alu_op, lui_op, auipc_op}
  task automatic drive32(input logic [2:0] msg, input logic dir, input logic [2:0] cls,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] ptr, input logic [7:0] info, input logic cancel);
    b32.in_valid  = 1'b1;
    b32.alu_msg   = msg;
    b32.alu_dir   = dir;
    b32.alu_op    = cls[2];
    b32.lui_op    = cls[1];
    b32.auipc_op  = cls[0];
    b32.src1      = a;
    b32.src2      = b;
    b32.in_ptr    = ptr;
    b32.in_info   = info;
    b32.in_cancel = cancel;
  endtask

  task automatic push32(input logic [4:0] ptr, input logic cancel);
    drive32(3'b000, 1'b0, 3'b100, 32'(ptr), 32'd0, ptr, 8'(ptr) ^ 8'h5A, cancel);
  endtask

  task automatic drive64(input logic [2:0] msg, input logic dir,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] ptr);
    b64.in_valid  = 1'b1;
    b64.alu_msg   = msg;
    b64.alu_dir   = dir;
    b64.alu_op    = 1'b1;
    b64.lui_op    = 1'b0;
    b64.auipc_op  = 1'b0;
    b64.src1      = a;
    b64.src2      = b;
    b64.in_ptr    = ptr;
    b64.in_info   = 8'h64;
    b64.in_cancel = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  msg;
    logic        dir;
    logic [2:0]  cls;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 16;
  vec_t vt [NV];

  typedef struct {
    logic [2:0]  msg;
    logic        dir;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec64_t;

  vec64_t v64 [3];

  initial begin
    vt[0]  = '{3'b000, 1'b0, 3'b100, 32'd3,         32'd4,         32'd7};          // add
    vt[1]  = '{3'b000, 1'b1, 3'b100, 32'd5,         32'd7,         32'hFFFF_FFFE};  // sub
    vt[2]  = '{3'b001, 1'b0, 3'b100, 32'd1,         32'd33,        32'd2};          // sll, shamt=1
    vt[3]  = '{3'b010, 1'b0, 3'b100, 32'hFFFF_FFFF, 32'd1,         32'd1};          // slt(-1,1)
    vt[4]  = '{3'b011, 1'b0, 3'b100, 32'hFFFF_FFFF, 32'd1,         32'd0};          // sltu(-1,1)
    vt[5]  = '{3'b010, 1'b0, 3'b100, 32'd1,         32'hFFFF_FFFF, 32'd0};          // slt(1,-1)
    vt[6]  = '{3'b011, 1'b0, 3'b100, 32'd1,         32'hFFFF_FFFF, 32'd1};          // sltu(1,big)
    vt[7]  = '{3'b100, 1'b0, 3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};  // xor
    vt[8]  = '{3'b101, 1'b0, 3'b100, 32'h8000_0000, 32'd4,         32'h0800_0000};  // srl
    vt[9]  = '{3'b101, 1'b1, 3'b100, 32'h8000_0000, 32'd4,         32'hF800_0000};  // sra
    vt[10] = '{3'b110, 1'b0, 3'b100, 32'h0F00_000F, 32'h0000_00F0, 32'h0F00_00FF};  // or
    vt[11] = '{3'b111, 1'b0, 3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};  // and
    vt[12] = '{3'b101, 1'b1, 3'b010, 32'h1234_5000, 32'd0,         32'h1234_5000};  // lui ignores msg
    vt[13] = '{3'b000, 1'b0, 3'b001, 32'h8000_0000, 32'h0000_1000, 32'h8000_1000};  // auipc
    vt[14] = '{3'b000, 1'b0, 3'b000, 32'd5,         32'd6,         32'd0};          // no class
    vt[15] = '{3'b000, 1'b0, 3'b100, 32'hFFFF_FFFF, 32'd1,         32'd0};          // add wraps

    v64[0] = '{3'b001, 1'b0, 64'd1, 64'd63, 64'h8000_0000_0000_0000};
    v64[1] = '{3'b000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0};
    v64[2] = '{3'b101, 1'b1, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000};

    // ---------------- reset ----------------
    rst = 1'b1;
    b32.in_valid = 0; b32.in_cancel = 0; b32.src1 = 0; b32.src2 = 0; b32.alu_msg = 0;
    b32.alu_dir = 0; b32.alu_op = 0; b32.lui_op = 0; b32.auipc_op = 0; b32.in_ptr = 0;
    b32.in_info = 0; b32.wb_ready = 0; b32.flush = 0;
    b64.in_valid = 0; b64.in_cancel = 0; b64.src1 = 0; b64.src2 = 0; b64.alu_msg = 0;
    b64.alu_dir = 0; b64.alu_op = 0; b64.lui_op = 0; b64.auipc_op = 0; b64.in_ptr = 0;
    b64.in_info = 0; b64.wb_ready = 0; b64.flush = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready",  64'(b32.in_ready),  64'd1);
    chk("reset wb_valid",  64'(b32.wb_valid),  64'd0);
    chk("reset occupancy", 64'(b32.occupancy), 64'd0);
    chk("reset wb_data",   64'(b32.wb_data),   64'd0);
    chk("reset wb_ptr",    64'(b32.wb_ptr),    64'd0);

    // ---------------- arithmetic table, XLEN=32 ----------------
    b32.wb_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive32(vt[i].msg, vt[i].dir, vt[i].cls, vt[i].a, vt[i].b, 5'(i), 8'hA0 + 8'(i), 1'b0);
      @(negedge clk);
      b32.in_valid = 1'b0;
      chk($sformatf("arith[%0d] wb_valid", i), 64'(b32.wb_valid), 64'd1);
      chk($sformatf("arith[%0d] wb_data", i),  64'(b32.wb_data),  64'(vt[i].exp));
      chk($sformatf("arith[%0d] wb_ptr", i),   64'(b32.wb_ptr),   64'(i));
      chk($sformatf("arith[%0d] wb_info", i),  64'(b32.wb_info),  64'(8'hA0 + 8'(i)));
      @(negedge clk);
    end
    chk("arith drained occupancy", 64'(b32.occupancy), 64'd0);

    // ---------------- backpressure ----------------
    b32.wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push32(5'(i), 1'b0);
      @(negedge clk);
      if (i == 2) chk("bp in_ready after 3 accepts", 64'(b32.in_ready), 64'd1);
    end
    chk("bp in_ready after 4 accepts", 64'(b32.in_ready),  64'd0);
    chk("bp occupancy full",           64'(b32.occupancy), 64'd4);
    push32(5'd4, 1'b0);
    @(negedge clk);
    chk("bp 5th op held off", 64'(b32.occupancy), 64'd4);
    b32.wb_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      logic acc;
      acc = b32.in_valid && b32.in_ready;
      chk($sformatf("bp drain[%0d] wb_valid", k), 64'(b32.wb_valid), 64'd1);
      chk($sformatf("bp drain[%0d] wb_ptr", k),   64'(b32.wb_ptr),   64'(k));
      chk($sformatf("bp drain[%0d] wb_data", k),  64'(b32.wb_data),  64'(k));
      @(negedge clk);
      if (acc) b32.in_valid = 1'b0;
    end
    chk("bp drained occupancy", 64'(b32.occupancy), 64'd0);

    // ---------------- cancel ----------------
    begin
      int nhs;
      logic [4:0] seen [2];
      int saw2;
      nhs = 0; saw2 = 0;
      for (int c = 0; c < 8; c++) begin
        if (b32.wb_valid && b32.wb_ready) begin
          if (nhs < 2) seen[nhs] = b32.wb_ptr;
          nhs++;
        end
        if (b32.wb_valid && b32.wb_ptr == 5'd2) saw2++;
        if (c < 3) push32(5'(c + 1), c == 1);
        else       b32.in_valid = 1'b0;
        @(negedge clk);
      end
      chk("cancel handshake count", 64'(nhs),     64'd2);
      chk("cancel first ptr",       64'(seen[0]), 64'd1);
      chk("cancel second ptr",      64'(seen[1]), 64'd3);
      chk("cancel ptr2 never valid", 64'(saw2),   64'd0);
      chk("cancel occupancy",       64'(b32.occupancy), 64'd0);
    end

    // ---------------- flush ----------------
    b32.wb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push32(5'(i + 5), 1'b0);
      @(negedge clk);
    end
    b32.in_valid = 1'b0;
    chk("flush pre occupancy", 64'(b32.occupancy), 64'd3);
    b32.flush = 1'b1;
    b32.wb_ready = 1'b1;
    push32(5'd9, 1'b0);
    #1;
    chk("flush cycle wb_valid", 64'(b32.wb_valid), 64'd0);
    @(negedge clk);
    b32.flush = 1'b0;
    b32.in_valid = 1'b0;
    chk("flush post occupancy", 64'(b32.occupancy), 64'd0);
    chk("flush post wb_valid",  64'(b32.wb_valid),  64'd0);
    begin
      int nv;
      nv = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (b32.wb_valid) nv++;
      end
      chk("flush offered op never appears", 64'(nv), 64'd0);
    end

    // ---------------- reset mid-stream ----------------
    b32.wb_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push32(5'(i + 12), 1'b0);
      @(negedge clk);
    end
    b32.in_valid = 1'b0;
    rst = 1'b1;
    b32.wb_ready = 1'b1;
    #1;
    chk("reset cycle wb_valid", 64'(b32.wb_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("mid reset occupancy", 64'(b32.occupancy), 64'd0);
    chk("mid reset in_ready",  64'(b32.in_ready),  64'd1);

    // ---------------- steady push/pop at occupancy 2 ----------------
    b32.wb_ready = 1'b0;
    push32(5'd10, 1'b0); @(negedge clk);
    push32(5'd11, 1'b0); @(negedge clk);
    b32.wb_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      push32(5'(12 + k), 1'b0);
      chk($sformatf("steady[%0d] occupancy", k), 64'(b32.occupancy), 64'd2);
      chk($sformatf("steady[%0d] wb_ptr", k),    64'(b32.wb_ptr),    64'(10 + k));
      chk($sformatf("steady[%0d] wb_data", k),   64'(b32.wb_data),   64'(10 + k));
      @(negedge clk);
    end
    b32.in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("steady tail[%0d] wb_ptr", k), 64'(b32.wb_ptr), 64'(20 + k));
      @(negedge clk);
    end
    chk("steady final occupancy", 64'(b32.occupancy), 64'd0);

    // ---------------- XLEN=64 build ----------------
    b64.wb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive64(v64[i].msg, v64[i].dir, v64[i].a, v64[i].b, 5'(i));
      @(negedge clk);
      b64.in_valid = 1'b0;
      chk($sformatf("x64[%0d] wb_valid", i), 64'(b64.wb_valid), 64'd1);
      chk($sformatf("x64[%0d] wb_data", i),  b64.wb_data,       v64[i].exp);
      chk($sformatf("x64[%0d] wb_ptr", i),   64'(b64.wb_ptr),   64'(i));
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
